// File: rtl/mips_mc_ctrl_pkg.sv
// Shared encodings for the P4 multi-cycle MIPS controller and datapath.
// Opcodes, functs, FSM states and datapath select codes.
package mips_mc_ctrl_pkg;

   localparam int MEM_TIMEOUT_DEF = 16;
   localparam int TO_W_DEF        = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_NOP = 6'h00;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_LUI = 2'd3;

   localparam logic [1:0] PC_SEQ = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_REG = 2'd3;

   localparam logic [1:0] RD_RT = 2'd0;
   localparam logic [1:0] RD_RD = 2'd1;
   localparam logic [1:0] RD_RA = 2'd2;

   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC4 = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   typedef struct packed {
      logic add;
      logic sub;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic j;
      logic jal;
      logic jr;
      logic nop;
   } cls_t;

   typedef struct packed {
      logic       mem_re;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic [1:0] alu_op;
      logic       alu_src_b;
      logic       ext_op;
      logic       instr_done;
      logic       illegal;
      logic       fault;
   } ctrl_t;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle.
// master = controller, slave = datapath side.
interface mips_mc_ctrl_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_re;
   logic       mem_we;
   logic       ir_we;
   logic       pc_we;
   logic [1:0] pc_src;
   logic       reg_we;
   logic [1:0] reg_dst;
   logic [1:0] wd_sel;
   logic [1:0] alu_op;
   logic       alu_src_b;
   logic       ext_op;
   logic       instr_done;
   logic       illegal;
   logic       fault;

   modport master (
      input  opcode, funct, zero, mem_ready,
      output mem_re, mem_we, ir_we, pc_we, pc_src,
      output reg_we, reg_dst, wd_sel, alu_op,
      output alu_src_b, ext_op, instr_done,
      output illegal, fault
   );

   modport slave (
      output opcode, funct, zero, mem_ready,
      input  mem_re, mem_we, ir_we, pc_we, pc_src,
      input  reg_we, reg_dst, wd_sel, alu_op,
      input  alu_src_b, ext_op, instr_done,
      input  illegal, fault
   );
endinterface

// File: rtl/mips_mc_decode.sv
// Opcode/funct to one-hot instruction class.
// An all-zero class vector means unsupported encoding.
module mips_mc_decode
   import mips_mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output cls_t       cls,
   output logic       illegal
);

   logic rtype;

   always_comb begin
      rtype   = (opcode == OP_RTYPE);
      cls     = '0;
      cls.add = rtype && (funct == FN_ADD);
      cls.sub = rtype && (funct == FN_SUB);
      cls.jr  = rtype && (funct == FN_JR);
      cls.nop = rtype && (funct == FN_NOP);
      cls.ori = (opcode == OP_ORI);
      cls.lw  = (opcode == OP_LW);
      cls.sw  = (opcode == OP_SW);
      cls.beq = (opcode == OP_BEQ);
      cls.lui = (opcode == OP_LUI);
      cls.j   = (opcode == OP_J);
      cls.jal = (opcode == OP_JAL);
      illegal = (cls == '0);
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle control FSM for the P4 MIPS datapath with a
// memory-wait watchdog that parks in a sticky FAULT state.
module mips_mc_ctrl
   import mips_mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int TO_W        = TO_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);

   state_t          st, nxt;
   logic [TO_W-1:0] wd_cnt, wd_nxt;
   cls_t            cls;
   logic            bad_op;
   logic            waiting;
   ctrl_t           c;

   mips_mc_decode u_dec (
      .opcode  (bus.opcode),
      .funct   (bus.funct),
      .cls     (cls),
      .illegal (bad_op)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= S_FETCH;
         wd_cnt <= '0;
      end else begin
         st     <= nxt;
         wd_cnt <= wd_nxt;
      end
   end

   always_comb begin
      c       = '0;
      nxt     = st;
      waiting = 1'b0;
      unique case (st)
         S_FETCH: begin
            c.mem_re = 1'b1;
            if (bus.mem_ready) begin
               c.ir_we  = 1'b1;
               c.pc_we  = 1'b1;
               c.pc_src = PC_SEQ;
               nxt      = S_DECODE;
            end else begin
               waiting = 1'b1;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               cls.j, cls.jal: begin
                  c.pc_we      = 1'b1;
                  c.pc_src     = PC_JMP;
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
                  if (cls.jal) begin
                     c.reg_we  = 1'b1;
                     c.reg_dst = RD_RA;
                     c.wd_sel  = WD_PC4;
                  end
               end
               cls.jr: begin
                  c.pc_we      = 1'b1;
                  c.pc_src     = PC_REG;
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
               end
               cls.nop: begin
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
               end
               bad_op: begin
                  c.illegal    = 1'b1;
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
               end
               default: nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            unique case (1'b1)
               cls.add, cls.sub: begin
                  c.alu_op = cls.sub ? ALU_SUB : ALU_ADD;
                  nxt      = S_WB;
               end
               cls.ori: begin
                  c.alu_op    = ALU_OR;
                  c.alu_src_b = 1'b1;
                  nxt         = S_WB;
               end
               cls.lui: begin
                  c.alu_op    = ALU_LUI;
                  c.alu_src_b = 1'b1;
                  nxt         = S_WB;
               end
               cls.lw, cls.sw: begin
                  c.alu_op    = ALU_ADD;
                  c.alu_src_b = 1'b1;
                  c.ext_op    = 1'b1;
                  nxt         = S_MEM;
               end
               cls.beq: begin
                  c.alu_op     = ALU_SUB;
                  c.ext_op     = 1'b1;
                  c.pc_we      = bus.zero;
                  c.pc_src     = PC_BR;
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            // address stays on the ALU for the whole access
            c.alu_op    = ALU_ADD;
            c.alu_src_b = 1'b1;
            c.ext_op    = 1'b1;
            if (cls.lw) begin
               c.mem_re = 1'b1;
               if (bus.mem_ready) nxt = S_WB;
               else waiting = 1'b1;
            end else if (cls.sw) begin
               c.mem_we = 1'b1;
               if (bus.mem_ready) begin
                  c.instr_done = 1'b1;
                  nxt          = S_FETCH;
               end else begin
                  waiting = 1'b1;
               end
            end else begin
               nxt = S_FETCH;
            end
         end
         S_WB: begin
            c.reg_we     = 1'b1;
            c.reg_dst    = (cls.add | cls.sub) ? RD_RD : RD_RT;
            c.wd_sel     = cls.lw ? WD_MEM : WD_ALU;
            c.instr_done = 1'b1;
            nxt          = S_FETCH;
         end
         S_FAULT: c.fault = 1'b1;
         default: nxt = S_FETCH;
      endcase

      wd_nxt = waiting ? wd_cnt + 1'b1 : '0;
      if (waiting && wd_cnt == TO_W'(MEM_TIMEOUT - 1))
         nxt = S_FAULT;

      if (reset) c = '0;
   end

   assign bus.mem_re     = c.mem_re;
   assign bus.mem_we     = c.mem_we;
   assign bus.ir_we      = c.ir_we;
   assign bus.pc_we      = c.pc_we;
   assign bus.pc_src     = c.pc_src;
   assign bus.reg_we     = c.reg_we;
   assign bus.reg_dst    = c.reg_dst;
   assign bus.wd_sel     = c.wd_sel;
   assign bus.alu_op     = c.alu_op;
   assign bus.alu_src_b  = c.alu_src_b;
   assign bus.ext_op     = c.ext_op;
   assign bus.instr_done = c.instr_done;
   assign bus.illegal    = c.illegal;
   assign bus.fault      = c.fault;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Randomized bench for mips_mc_ctrl: a per-instruction cycle
// script model built from the ISA table, compared every cycle.
module tb_mips_mc_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_mc_ctrl_if bus ();

   mips_mc_ctrl #(
      .MEM_TIMEOUT (16),
      .TO_W        (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic       mem_re;
      logic       mem_we;
      logic       ir_we;
      logic       pc_we;
      logic [1:0] pc_src;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic [1:0] alu_op;
      logic       src_b;
      logic       ext;
      logic       done;
      logic       ill;
      logic       fault;
   } vec_t;

   typedef struct {
      logic mr;
      logic z;
      vec_t v;
   } step_t;

   localparam int C_ADD = 0, C_SUB = 1, C_ORI = 2, C_LW = 3;
   localparam int C_SW = 4, C_BEQ = 5, C_LUI = 6, C_J = 7;
   localparam int C_JAL = 8, C_JR = 9, C_NOP = 10, C_ILL = 11;

   step_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   task automatic check(string tag, logic [31:0] got,
                        logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic vec_t observe();
      vec_t o;
      o.mem_re  = bus.mem_re;
      o.mem_we  = bus.mem_we;
      o.ir_we   = bus.ir_we;
      o.pc_we   = bus.pc_we;
      o.pc_src  = bus.pc_src;
      o.reg_we  = bus.reg_we;
      o.reg_dst = bus.reg_dst;
      o.wd_sel  = bus.wd_sel;
      o.alu_op  = bus.alu_op;
      o.src_b   = bus.alu_src_b;
      o.ext     = bus.ext_op;
      o.done    = bus.instr_done;
      o.ill     = bus.illegal;
      o.fault   = bus.fault;
      return o;
   endfunction

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   task automatic push(logic mr, logic z, vec_t v);
      step_t s;
      s.mr = mr;
      s.z  = z;
      s.v  = v;
      q.push_back(s);
   endtask

   task automatic set_instr(int c);
      logic [5:0] op, fn;
      op = 6'h00;
      fn = 6'($urandom);
      case (c)
         C_ADD: fn = 6'h20;
         C_SUB: fn = 6'h22;
         C_JR:  fn = 6'h08;
         C_NOP: fn = 6'h00;
         C_ORI: op = 6'h0d;
         C_LW:  op = 6'h23;
         C_SW:  op = 6'h2b;
         C_BEQ: op = 6'h04;
         C_LUI: op = 6'h0f;
         C_J:   op = 6'h02;
         C_JAL: op = 6'h03;
         default: begin
            do op = 6'($urandom);
            while (op inside {6'h02, 6'h03, 6'h04, 6'h0d,
                              6'h0f, 6'h23, 6'h2b});
            if (op == 6'h00) begin
               do fn = 6'($urandom);
               while (fn inside {6'h00, 6'h08, 6'h20, 6'h22});
            end
         end
      endcase
      bus.opcode = op;
      bus.funct  = fn;
   endtask

   // Expected cycle script for one instruction.
   task automatic build(int c, int flat, int mlat, logic z);
      vec_t v, m, w;
      v = '0;
      v.mem_re = 1'b1;
      for (int i = 0; i < flat; i++) push(1'b0, rb(), v);
      v.ir_we = 1'b1;
      v.pc_we = 1'b1;
      push(1'b1, rb(), v);
      v = '0;
      if (c inside {C_J, C_JAL, C_JR, C_NOP, C_ILL}) begin
         v.done = 1'b1;
         if (c == C_J || c == C_JAL) begin
            v.pc_we  = 1'b1;
            v.pc_src = 2'd2;
         end
         if (c == C_JAL) begin
            v.reg_we  = 1'b1;
            v.reg_dst = 2'd2;
            v.wd_sel  = 2'd2;
         end
         if (c == C_JR) begin
            v.pc_we  = 1'b1;
            v.pc_src = 2'd3;
         end
         if (c == C_ILL) v.ill = 1'b1;
         push(rb(), rb(), v);
      end else begin
         push(rb(), rb(), v);
         case (c)
            C_SUB, C_BEQ: v.alu_op = 2'd1;
            C_ORI:        v.alu_op = 2'd2;
            C_LUI:        v.alu_op = 2'd3;
            default:      v.alu_op = 2'd0;
         endcase
         v.src_b = c inside {C_ORI, C_LUI, C_LW, C_SW};
         v.ext   = c inside {C_LW, C_SW, C_BEQ};
         if (c == C_BEQ) begin
            v.pc_we  = z;
            v.pc_src = 2'd1;
            v.done   = 1'b1;
            push(rb(), z, v);
         end else begin
            push(rb(), rb(), v);
         end
         if (c == C_LW || c == C_SW) begin
            m = '0;
            m.src_b  = 1'b1;
            m.ext    = 1'b1;
            m.mem_re = (c == C_LW);
            m.mem_we = (c == C_SW);
            for (int i = 0; i < mlat; i++) push(1'b0, rb(), m);
            m.done = (c == C_SW);
            push(1'b1, rb(), m);
         end
         if (c != C_BEQ && c != C_SW) begin
            w = '0;
            w.reg_we  = 1'b1;
            w.reg_dst = (c == C_ADD || c == C_SUB) ? 2'd1 : 2'd0;
            w.wd_sel  = (c == C_LW) ? 2'd1 : 2'd0;
            w.done    = 1'b1;
            push(rb(), rb(), w);
         end
      end
   endtask

   task automatic run_step(string tag, output logic done);
      step_t s;
      vec_t  o;
      s = q.pop_front();
      bus.mem_ready = s.mr;
      bus.zero      = s.z;
      @(negedge clk);
      o = observe();
      check(tag, 32'(o), 32'(s.v));
      if (o.mem_re && o.mem_we)
         check({tag, "_re_we"}, 32'd1, 32'd0);
      done = o.done;
      @(posedge clk);
      #1;
   endtask

   task automatic run_q(string tag, bit want_lat);
      int   n, cyc, first;
      logic d;
      n     = q.size();
      cyc   = 0;
      first = 0;
      while (q.size() > 0) begin
         cyc++;
         run_step(tag, d);
         if (d && first == 0) first = cyc;
      end
      if (want_lat) check({tag, "_lat"}, 32'(first), 32'(n));
   endtask

   task automatic do_reset(int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) begin
         bus.mem_ready = rb();
         bus.zero      = rb();
         @(negedge clk);
         check("reset_out", 32'(observe()), 32'd0);
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
   endtask

   task automatic instr(string tag, int c, int fl, int ml,
                        logic z);
      set_instr(c);
      build(c, fl, ml, z);
      run_q(tag, 1'b1);
   endtask

   initial begin
      vec_t f;
      logic d;
      int   c;
      reset         = 1'b1;
      bus.opcode    = 6'h00;
      bus.funct     = 6'h00;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      do_reset(2);

      instr("add", C_ADD, 0, 0, 1'b0);
      instr("lw_wait3", C_LW, 0, 3, 1'b0);
      instr("beq_z1", C_BEQ, 0, 0, 1'b1);
      instr("beq_z0", C_BEQ, 0, 0, 1'b0);
      instr("jal", C_JAL, 0, 0, 1'b0);
      instr("jr", C_JR, 0, 0, 1'b0);
      instr("illegal", C_ILL, 0, 0, 1'b0);
      instr("fetch_wait15", C_NOP, 15, 0, 1'b0);
      instr("sw_wait15", C_SW, 0, 15, 1'b0);
      instr("lw_wait15", C_LW, 15, 15, 1'b0);

      for (int i = 0; i < 300; i++) begin
         c = $urandom_range(0, 11);
         instr("rand", c, $urandom_range(0, 3),
               $urandom_range(0, 3), rb());
      end

      // reset in the middle of a store access
      set_instr(C_SW);
      build(C_SW, 0, 2, 1'b0);
      for (int i = 0; i < 4; i++) run_step("sw_pre", d);
      q.delete();
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      @(negedge clk);
      check("sw_rst_out", 32'(observe()), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      instr("after_sw_rst", C_ADD, 0, 0, 1'b0);

      // stuck memory in FETCH trips the watchdog
      f = '0;
      f.mem_re = 1'b1;
      for (int i = 0; i < 16; i++) push(1'b0, rb(), f);
      f = '0;
      f.fault = 1'b1;
      for (int i = 0; i < 5; i++) push(rb(), rb(), f);
      run_q("fault", 1'b0);
      do_reset(2);
      instr("after_fault", C_ORI, 1, 0, 1'b0);

      // stuck memory in MEM of a load
      set_instr(C_LW);
      build(C_LW, 0, 40, 1'b0);
      for (int i = 0; i < 19; i++) run_step("lw_to", d);
      q.delete();
      f = '0;
      f.fault = 1'b1;
      for (int i = 0; i < 3; i++) push(rb(), rb(), f);
      run_q("lw_fault", 1'b0);
      do_reset(1);
      instr("after_lw_fault", C_LUI, 0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "bench did not finish");
   end

endmodule
